// File: rtl/hypot_pkg.sv
// Shared widths, FSM state type and a width helper for the hypot scheduler.
package hypot_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = DATA_W + 1;
  localparam int unsigned SUM_W  = 2 * DATA_W + 1;
  localparam int unsigned SQ_W   = 2 * RES_W;
  localparam int unsigned K_W    = clog2(RES_W);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

endpackage

// File: rtl/hypot_iter_core.sv
// Bit-serial integer square root of x*x + y*y: one result bit per step, MSB first.
module hypot_iter_core
  import hypot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              last_c,
  output logic [RES_W-1:0]  root
);

  logic [SUM_W-1:0] sum;
  logic [K_W-1:0]   k;
  logic [RES_W-1:0] trial_c;
  logic [SQ_W-1:0]  trial_sq_c;

  // Candidate root with the current bit set, squared at full width.
  always_comb begin
    trial_c    = root | (RES_W'(1) << k);
    trial_sq_c = SQ_W'(trial_c) * SQ_W'(trial_c);
  end

  assign last_c = (k == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      root <= '0;
      k    <= '0;
    end else if (start) begin
      sum  <= SUM_W'(x) * SUM_W'(x) + SUM_W'(y) * SUM_W'(y);
      root <= '0;
      k    <= K_W'(RES_W - 1);
    end else if (step) begin
      if (trial_sq_c <= SQ_W'(sum)) root <= trial_c;
      if (k != '0) k <= k - K_W'(1);
    end
  end

endmodule

// File: rtl/hypot_sched.sv
// Round-robin scheduler sharing one iterative magnitude engine between NREQ requesters.
module hypot_sched
  import hypot_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned ID_W = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_x,
  input  logic [NREQ*DATA_W-1:0] req_y,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  output logic [RES_W-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  input  logic                   out_ready,
  output logic                   busy
);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] x_q, y_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rr_last;

  logic              grant_found_c;
  logic [ID_W-1:0]   grant_id_c;
  logic [DATA_W-1:0] sel_x_c, sel_y_c;
  logic              accept_c, transfer_c;
  logic              core_start_c, core_step_c, core_last_c;

  // Round-robin search starting one past the last served requester.
  always_comb begin : arb
    int unsigned idx;
    grant_found_c = 1'b0;
    grant_id_c    = '0;
    idx           = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(rr_last) + off) % NREQ;
      if (!grant_found_c && req_valid[ID_W'(idx)]) begin
        grant_found_c = 1'b1;
        grant_id_c    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_x_c = '0;
    sel_y_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id_c == ID_W'(i)) begin
        sel_x_c = req_x[i*DATA_W +: DATA_W];
        sel_y_c = req_y[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Nothing advances and no handshake fires while disabled or in reset.
  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    out_valid    = 1'b0;
    accept_c     = 1'b0;
    transfer_c   = 1'b0;
    core_start_c = 1'b0;
    core_step_c  = 1'b0;
    if (ena && !rst) begin
      case (state)
        IDLE: begin
          if (grant_found_c) begin
            req_ready[grant_id_c] = 1'b1;
            accept_c              = 1'b1;
            state_nxt             = LOAD;
          end
        end
        LOAD: begin
          core_start_c = 1'b1;
          state_nxt    = ITER;
        end
        ITER: begin
          core_step_c = 1'b1;
          if (core_last_c) state_nxt = DONE;
        end
        DONE: begin
          out_valid = 1'b1;
          if (out_ready) begin
            transfer_c = 1'b1;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      id_q    <= '0;
      rr_last <= ID_W'(NREQ - 1);
    end else begin
      if (accept_c) begin
        x_q  <= sel_x_c;
        y_q  <= sel_y_c;
        id_q <= grant_id_c;
      end
      if (transfer_c) rr_last <= id_q;
    end
  end

  hypot_iter_core u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (core_start_c),
    .step   (core_step_c),
    .x      (x_q),
    .y      (y_q),
    .last_c (core_last_c),
    .root   (out_data)
  );

  assign out_id = id_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_hypot_sched.sv
// Directed and randomized checks of the shared magnitude scheduler.
module tb_hypot_sched;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [8:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  hypot_sched #(.NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int isqrt(input int s);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int id, input int x, input int y);
    req_x[id*8 +: 8] = 8'(x);
    req_y[id*8 +: 8] = 8'(y);
  endtask

  // Drives one request on requester id and collects its result; ok=0 on timeout.
  task automatic do_job(input int id, input int x, input int y,
                        output logic [8:0] res, output logic [1:0] rid,
                        output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    res = '0;
    rid = '0;
    set_ops(id, x, y);
    req_valid[id] = 1'b1;
    #1;
    for (int i = 0; i < 40 && req_ready[id] !== 1'b1; i++) tick();
    if (req_ready[id] !== 1'b1) begin
      req_valid[id] = 1'b0;
      return;
    end
    tick();
    req_valid[id] = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (out_valid !== 1'b1) return;
    res = out_data;
    rid = out_id;
    ok  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; req_valid = 4'hf; req_x = '0; req_y = '0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({req_ready, out_valid, out_data, out_id, busy} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b valid=%b data=%0d id=%0d busy=%b exp all 0",
               req_ready, out_valid, out_data, out_id, busy);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int lat;
    set_ops(0, 3, 4);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      failures++; $display("FAIL single_ready_after_accept got ready=%b busy=%b exp 0000/1", req_ready, busy);
    end
    req_valid = '0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++;
    if (lat !== 11) begin failures++; $display("FAIL single_latency got=%0d exp=11", lat); end
    checks++;
    if (out_data !== 9'd5 || out_id !== 2'd0) begin
      failures++; $display("FAIL single_result got data=%0d id=%0d exp 5/0", out_data, out_id);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_idle got busy=%b valid=%b exp 0/0", busy, out_valid);
    end
  endtask

  task automatic test_bounds();
    int xs[4] = '{0, 255, 255, 1};
    int ys[4] = '{0, 255, 0, 1};
    int ex[4] = '{0, 360, 255, 1};
    logic [8:0] res; logic [1:0] rid; int lat; bit ok;
    for (int i = 0; i < 4; i++) begin
      do_job(i, xs[i], ys[i], res, rid, lat, ok);
      checks++;
      if (!ok || res !== 9'(ex[i]) || rid !== 2'(i) || lat !== 11) begin
        failures++;
        $display("FAIL bound_%0d got ok=%0d data=%0d id=%0d lat=%0d exp data=%0d id=%0d lat=11",
                 i, ok, res, rid, lat, ex[i], i);
      end
    end
  endtask

  task automatic test_round_robin();
    int ex[4]    = '{10, 13, 17, 29};
    int order[5] = '{0, 1, 2, 3, 0};
    int grants[5];
    int res_id[5];
    int res_d[5];
    int ngr, nres, cyc;
    bit multi;
    set_ops(0, 6, 8); set_ops(1, 5, 12); set_ops(2, 8, 15); set_ops(3, 20, 21);
    req_valid = 4'hf; out_ready = 1'b1;
    ngr = 0; nres = 0; cyc = 0; multi = 1'b0;
    for (int i = 0; i < 5; i++) begin grants[i] = -1; res_id[i] = -1; res_d[i] = -1; end
    #1;
    while (nres < 5 && cyc < 100) begin
      if ($countones(req_ready) > 1) multi = 1'b1;
      if (req_ready != 4'b0 && ngr < 5) begin
        for (int j = 0; j < 4; j++) if (req_ready[j]) grants[ngr] = j;
        ngr++;
      end
      if (out_valid === 1'b1) begin
        res_id[nres] = int'(out_id);
        res_d[nres]  = int'(out_data);
        nres++;
      end
      tick();
      cyc++;
    end
    req_valid = '0; out_ready = 1'b0;
    checks++;
    if (multi) begin failures++; $display("FAIL rr_onehot got multi=1 exp multi=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (grants[i] !== order[i]) begin
        failures++; $display("FAIL rr_grant_%0d got=%0d exp=%0d", i, grants[i], order[i]);
      end
      checks++;
      if (res_id[i] !== order[i] || res_d[i] !== ex[order[i]]) begin
        failures++;
        $display("FAIL rr_result_%0d got id=%0d data=%0d exp id=%0d data=%0d",
                 i, res_id[i], res_d[i], order[i], ex[order[i]]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bad;
    set_ops(2, 9, 12);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    tick();
    set_ops(1, 7, 24);
    req_valid = 4'b0010;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_data !== 9'd15 || out_id !== 2'd2 || req_ready !== 4'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold got valid=%b data=%0d id=%0d ready=%b exp 1/15/2/0000",
               out_valid, out_data, out_id, req_ready);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'd25 || out_id !== 2'd1) begin
      failures++; $display("FAIL bp_second got valid=%b data=%0d id=%0d exp 1/25/1", out_valid, out_data, out_id);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] res; logic [1:0] rid; int lat; bit ok; bit seen;
    set_ops(3, 100, 100);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL rstmid_grant got=%b exp=1000", req_ready); end
    tick();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, out_valid, out_data, out_id, busy} !== 17'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got ready=%b valid=%b data=%0d id=%0d busy=%b exp all 0",
               req_ready, out_valid, out_data, out_id, busy);
    end
    tick(); tick();
    rst = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin failures++; $display("FAIL rstmid_aborted got activity=1 exp 0"); end
    set_ops(0, 20, 21);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b1000;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'd29 || out_id !== 2'd0) begin
      failures++; $display("FAIL rstmid_job0 got valid=%b data=%0d id=%0d exp 1/29/0", out_valid, out_data, out_id);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    do_job(3, 100, 100, res, rid, lat, ok);
    checks++;
    if (!ok || res !== 9'd141 || rid !== 2'd3) begin
      failures++; $display("FAIL rstmid_job3 got ok=%0d data=%0d id=%0d exp 141/3", ok, res, rid);
    end
  endtask

  task automatic test_enable();
    int cnt;
    bit bad;
    set_ops(1, 12, 5);
    req_valid = 4'b0010;
    ena = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin failures++; $display("FAIL ena_idle_ready got=%b exp=0000", req_ready); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ena_idle_hold got busy=%b exp=0", busy); end
    ena = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL ena_grant got=%b exp=0010", req_ready); end
    tick(); cnt = 1;
    req_valid = '0;
    tick(); cnt++;
    tick(); cnt++;
    ena = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy !== 1'b1 || out_valid !== 1'b0 || req_ready !== 4'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL ena_iter_freeze got busy=%b valid=%b exp 1/0", busy, out_valid); end
    ena = 1'b1;
    while (out_valid !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    checks++;
    if (cnt !== 11 || out_data !== 9'd13 || out_id !== 2'd1) begin
      failures++; $display("FAIL ena_iter_result got lat=%0d data=%0d id=%0d exp 11/13/1", cnt, out_data, out_id);
    end
    ena = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ena_done_valid got=%b exp=0", out_valid); end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL ena_done_hold got busy=%b valid=%b exp 1/0", busy, out_valid);
    end
    ena = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'd13 || out_id !== 2'd1) begin
      failures++; $display("FAIL ena_done_resume got valid=%b data=%0d id=%0d exp 1/13/1", out_valid, out_data, out_id);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ena_done_transfer got busy=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int cx[4];
    int cy[4];
    int exp_id[$];
    int exp_val[$];
    int last_g, g, njobs, multi, bad_grant;
    for (int i = 0; i < 4; i++) begin
      cx[i] = $urandom_range(0, 255); cy[i] = $urandom_range(0, 255);
      set_ops(i, cx[i], cy[i]);
    end
    req_valid = 4'hf;
    last_g = -1; njobs = 0; multi = 0; bad_grant = 0;
    for (int cyc = 0; cyc < 20040; cyc++) begin
      if (cyc >= 20000) begin
        req_valid = '0;
        out_ready = 1'b1;
      end else begin
        if (last_g >= 0) begin
          cx[last_g] = $urandom_range(0, 255); cy[last_g] = $urandom_range(0, 255);
          set_ops(last_g, cx[last_g], cy[last_g]);
          req_valid[last_g] = ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) begin
          if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
            cx[i] = $urandom_range(0, 255); cy[i] = $urandom_range(0, 255);
            set_ops(i, cx[i], cy[i]);
            req_valid[i] = 1'b1;
          end
        end
        out_ready = 1'($urandom_range(0, 1));
      end
      last_g = -1;
      #1;
      if ($countones(req_ready) > 1) multi++;
      if (req_ready != 4'b0) begin
        g = 0;
        for (int j = 0; j < 4; j++) if (req_ready[j]) g = j;
        if (!req_valid[g]) bad_grant++;
        exp_id.push_back(g);
        exp_val.push_back(isqrt(cx[g] * cx[g] + cy[g] * cy[g]));
        last_g = g;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_id.size() == 0) begin
          failures++; $display("FAIL rand_unexpected got data=%0d id=%0d exp none", out_data, out_id);
        end else begin
          if (out_data !== 9'(exp_val[0]) || out_id !== 2'(exp_id[0])) begin
            failures++;
            $display("FAIL rand_job_%0d got data=%0d id=%0d exp data=%0d id=%0d",
                     njobs, out_data, out_id, exp_val[0], exp_id[0]);
          end
          void'(exp_id.pop_front());
          void'(exp_val.pop_front());
        end
        njobs++;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (exp_id.size() != 0 || njobs < 500) begin
      failures++; $display("FAIL rand_drain got pending=%0d jobs=%0d exp 0/>=500", exp_id.size(), njobs);
    end
    checks++;
    if (multi != 0 || bad_grant != 0) begin
      failures++; $display("FAIL rand_grants got multi=%0d bad=%0d exp 0/0", multi, bad_grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounds();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
